// File: rtl/gf_reduce_seq.sv
// Sequential reducer: folds a 2N-bit product to N bits, either modulo a GF(2^N)
// polynomial (one bit per cycle, MSB first) or by plain truncation.
module gf_reduce_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      gf_option,
    input  logic [2*DATA_WIDTH-1:0]   product,
    input  logic [DATA_WIDTH-1:0]     poly,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     result,
    output logic                      busy,
    output logic [1:0]                fsm_state
);

    // Handshake: a product transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready.
    // in_ready/out_valid/busy are decoded from state only.

    localparam int N  = DATA_WIDTH;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(2 * N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [2*N-1:0]  rem, rem_next, rem_step, poly_shifted;
    logic [N-1:0]    poly_r, poly_r_next;
    logic [N-1:0]    result_r, result_next;
    logic            opt_r, opt_r_next;
    logic [KW-1:0]   k, k_next;
    logic [IW-1:0]   lead_idx;
    logic            lead;

    // The divisor is x^N + poly, aligned so its x^N term sits on rem[N+k].
    assign poly_shifted = {{(N-1){1'b0}}, 1'b1, poly_r} << k;
    assign lead_idx     = IW'(N) + IW'(k);
    assign lead         = rem[lead_idx];
    assign rem_step     = (opt_r && lead) ? (rem ^ poly_shifted) : rem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem      <= '0;
            poly_r   <= '0;
            opt_r    <= 1'b0;
            k        <= '0;
            result_r <= '0;
        end else begin
            state    <= state_next;
            rem      <= rem_next;
            poly_r   <= poly_r_next;
            opt_r    <= opt_r_next;
            k        <= k_next;
            result_r <= result_next;
        end
    end

    always_comb begin
        state_next  = state;
        rem_next    = rem;
        poly_r_next = poly_r;
        opt_r_next  = opt_r;
        k_next      = k;
        result_next = result_r;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    rem_next    = product;
                    poly_r_next = poly;
                    opt_r_next  = gf_option;
                    if (gf_option) begin
                        state_next = REDUCE;
                        k_next     = KW'(N - 1);
                    end else begin
                        state_next  = DONE;
                        result_next = product[N-1:0];
                    end
                end
            end
            REDUCE: begin
                rem_next = rem_step;
                if (k == '0) begin
                    state_next  = DONE;
                    result_next = rem_step[N-1:0];
                end else begin
                    k_next = k - KW'(1);
                end
            end
            DONE: begin
                // Returning to IDLE here means the next product waits one edge.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = result_r;
    assign fsm_state = state;

endmodule

// File: tb/tb_gf_reduce_seq.sv
// Directed bench for gf_reduce_seq at DATA_WIDTH=8 with an expected-result queue
// fed at drive time and drained when the DUT presents a result.
module tb_gf_reduce_seq;

    localparam int W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             gf_option;
    logic [2*W-1:0]   product;
    logic [W-1:0]     poly;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic             busy;
    logic [1:0]       fsm_state;

    logic [W-1:0] exp_q[$];
    int total;
    int bad;

    gf_reduce_seq #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gf_option (gf_option),
        .product   (product),
        .poly      (poly),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of x^i mod p over the set bits, with x^i built by repeated xtime.
    function automatic logic [W-1:0] model(input bit opt, input logic [W-1:0] pl,
                                           input logic [2*W-1:0] pr);
        logic [W-1:0] t;
        logic [W-1:0] acc;
        if (!opt) return pr[W-1:0];
        t   = 1;
        acc = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (pr[i]) acc ^= t;
            t = {t[W-2:0], 1'b0} ^ (t[W-1] ? pl : '0);
        end
        return acc;
    endfunction

    task automatic pop_check(input string tag);
        logic [W-1:0] e;
        check({tag, "_qdepth"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_result"}, result, e);
        end
    endtask

    // driver: one full transaction with latency and handshake checks
    task automatic do_txn(input string tag, input bit opt, input logic [W-1:0] pl,
                          input logic [2*W-1:0] pr, input int exp_lat, input logic [W-1:0] exp_const);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_ready_wait"}, guard < 50, 1);
        gf_option = opt;
        poly      = pl;
        product   = pr;
        in_valid  = 1'b1;
        exp_q.push_back(model(opt, pl, pr));
        tick();
        in_valid  = 1'b0;
        product   = 16'($urandom);
        poly      = 8'($urandom);
        gf_option = 1'($urandom);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready_low"}, in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            check({tag, "_in_ready_wait"}, in_ready, 0);
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_const"}, result, exp_const);
        pop_check(tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_back_idle_ready"}, in_ready, 1);
        check({tag, "_back_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        logic [W-1:0]   e;
        logic [2*W-1:0] vec[5];
        int n_acc;
        int n_res;
        int cyc;
        int last_acc;
        bit acc_now;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        gf_option = 1'b0;
        product   = '0;
        poly      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_state", fsm_state, 0);

        // first edge out of reset must accept
        rst_n = 1'b1;
        do_txn("aes_first", 1'b1, 8'h1B, 16'h2B79, 9, 8'hC1);
        do_txn("x8", 1'b1, 8'h1B, 16'h0100, 9, 8'h1B);
        do_txn("low_only", 1'b1, 8'h1B, 16'h00C1, 9, 8'hC1);
        do_txn("poly_zero", 1'b1, 8'h00, 16'hABCD, 9, 8'hCD);
        do_txn("int", 1'b0, 8'h1B, 16'h1234, 1, 8'h34);

        // stall in DONE with a competing input that must be ignored
        gf_option = 1'b0;
        product   = 16'h5678;
        in_valid  = 1'b1;
        exp_q.push_back(model(1'b0, 8'h1B, 16'h5678));
        tick();
        gf_option = 1'b1;
        product   = 16'h9999;
        poly      = 8'h1B;
        check("stall_valid0", out_valid, 1);
        check("stall_qdepth", exp_q.size() > 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int i = 0; i < 5; i++) begin
            check("stall_result", result, e);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            tick();
        end
        check("stall_result_end", result, 8'h78);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_release_valid", out_valid, 0);
        check("stall_release_ready", in_ready, 1);
        check("stall_no_same_edge_accept", busy, 0);
        in_valid = 1'b0;

        // reset while reducing at k=3
        gf_option = 1'b1;
        poly      = 8'h1B;
        product   = 16'h2B79;
        in_valid  = 1'b1;
        exp_q.push_back(model(1'b1, 8'h1B, 16'h2B79));
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("midrst_in_reduce", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        for (int i = 0; i < 12; i++) begin
            check("midrst_no_output", out_valid, 0);
            tick();
        end
        do_txn("after_rst", 1'b1, 8'h1B, 16'h2B79, 9, 8'hC1);

        // random GF vectors, a different polynomial each time
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0]   pl;
            logic [2*W-1:0] pr;
            pl = 8'($urandom_range(0, 255));
            pr = 16'($urandom_range(0, 65535));
            do_txn("rand_gf", 1'b1, pl, pr, 9, model(1'b1, pl, pr));
        end

        // back-to-back with out_ready tied high
        for (int i = 0; i < 5; i++) vec[i] = 16'($urandom_range(0, 65535));
        n_acc     = 0;
        n_res     = 0;
        cyc       = 0;
        last_acc  = 0;
        gf_option = 1'b1;
        poly      = 8'h1B;
        product   = vec[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (n_res < 5 && cyc < 200) begin
            acc_now = 1'b0;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(1'b1, 8'h1B, vec[n_acc]));
                if (n_acc > 0) check("b2b_spacing", cyc - last_acc, 10);
                last_acc = cyc;
                n_acc++;
                acc_now = 1'b1;
            end
            if (out_valid && out_ready) begin
                pop_check("b2b");
                n_res++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                if (n_acc < 5) product = vec[n_acc];
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_in_time", cyc < 200, 1);
        check("b2b_accepts", n_acc, 5);
        check("b2b_results", n_res, 5);
        check("b2b_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
